// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : disp_pkg
//  Description : Shared types and constants for the dual-issue dispatch
//                controller: instruction class encoding, RV32 opcode/funct7
//                fields used for classification, the canonical NOP word and
//                the dispatch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Instruction class as presented on disp*_class.
    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_ALU = 2'd1,
        CLS_MUL = 2'd2,
        CLS_LD  = 2'd3
    } instr_class_t;

    localparam logic [6:0]  c_OPC_LOAD      = 7'b0000011;
    localparam logic [6:0]  c_OPC_OP        = 7'b0110011;
    localparam logic [6:0]  c_FUNCT7_MULDIV = 7'b0000001;
    // addi x0, x0, 0 - the canonical NOP encoding.
    localparam logic [31:0] c_NOP_WORD      = 32'h0000_0013;

    // Dispatch FSM: RUN dispatches normally, HOLD blocks dispatch after a flush.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } disp_state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/instr_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : instr_classifier
//  Description : Combinational decode of a 32-bit instruction word into its
//                dispatch class (NOP / ALU / MUL / LD).
//  Ports       : instr       - 32-bit instruction word
//                instr_class - decoded class
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_classifier
    import disp_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;

    assign w_opcode = instr[6:0];
    assign w_funct7 = instr[31:25];

    // The exact NOP word is checked first: it shares its opcode with the
    // ALU immediate group and must not be counted as an ALU operation.
    always_comb begin
        instr_class = CLS_ALU;
        if (instr == c_NOP_WORD) begin
            instr_class = CLS_NOP;
        end else if (w_opcode == c_OPC_LOAD) begin
            instr_class = CLS_LD;
        end else if ((w_opcode == c_OPC_OP) && (w_funct7 == c_FUNCT7_MULDIV)) begin
            instr_class = CLS_MUL;
        end
    end

endmodule : instr_classifier
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_ctrl
//  Description : Two-wide in-order dispatch controller. Classifies the two
//                head instructions, checks reservation-station credit per
//                class, and tells the instruction queue how far to advance.
//                A flush blocks dispatch for FLUSH_CYCLES cycles and restores
//                all credit.
//  Ports       : clk, reset (async, active-low)
//                instr1/instr2           - head / head+1 instruction words
//                rel_alu/rel_mul/rel_ld  - one entry of that class freed
//                flush                   - squash pulse
//                shift_count             - number of slots dispatched (0..2)
//                disp1/2_valid, _class   - per-slot dispatch and class
//                stall_count             - RUN cycles with zero dispatch
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ctrl
    import disp_pkg::*;
#(
    parameter int ALU_SLOTS    = 4,
    parameter int MUL_SLOTS    = 2,
    parameter int LD_SLOTS     = 3,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr1,
    input  logic [31:0] instr2,
    input  logic        rel_alu,
    input  logic        rel_mul,
    input  logic        rel_ld,
    input  logic        flush,
    output logic [1:0]  shift_count,
    output logic        disp1_valid,
    output logic        disp2_valid,
    output logic [1:0]  disp1_class,
    output logic [1:0]  disp2_class,
    output logic [15:0] stall_count
);

    localparam int c_ALU_W  = $clog2(ALU_SLOTS + 1);
    localparam int c_MUL_W  = $clog2(MUL_SLOTS + 1);
    localparam int c_LD_W   = $clog2(LD_SLOTS + 1);
    localparam int c_HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [c_ALU_W-1:0]  c_ALU_MAX   = c_ALU_W'(ALU_SLOTS);
    localparam logic [c_MUL_W-1:0]  c_MUL_MAX   = c_MUL_W'(MUL_SLOTS);
    localparam logic [c_LD_W-1:0]   c_LD_MAX    = c_LD_W'(LD_SLOTS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(FLUSH_CYCLES - 1);

    disp_state_t         r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_ALU_W-1:0]  r_free_alu;
    logic [c_MUL_W-1:0]  r_free_mul;
    logic [c_LD_W-1:0]   r_free_ld;
    logic [15:0]         r_stall;

    instr_class_t w_class1;
    instr_class_t w_class2;
    logic         w_run;
    logic         w_slot1_ok;
    logic         w_slot2_ok;
    logic         w_d1;
    logic         w_d2;
    logic [1:0]   w_alloc_alu;
    logic [1:0]   w_alloc_mul;
    logic [1:0]   w_alloc_ld;
    logic [c_ALU_W:0] w_alu_sum;
    logic [c_MUL_W:0] w_mul_sum;
    logic [c_LD_W:0]  w_ld_sum;
    logic [c_ALU_W-1:0] w_alu_nxt;
    logic [c_MUL_W-1:0] w_mul_nxt;
    logic [c_LD_W-1:0]  w_ld_nxt;

    instr_classifier u_cls1 (.instr(instr1), .instr_class(w_class1));
    instr_classifier u_cls2 (.instr(instr2), .instr_class(w_class2));

    // Reset is folded in so outputs read zero while reset is held low,
    // independent of whatever the queue is presenting.
    assign w_run = reset && (r_state == ST_RUN) && !flush;

    always_comb begin
        w_slot1_ok = 1'b1;
        case (w_class1)
            CLS_ALU: w_slot1_ok = (r_free_alu != '0);
            CLS_MUL: w_slot1_ok = (r_free_mul != '0);
            CLS_LD:  w_slot1_ok = (r_free_ld  != '0);
            default: w_slot1_ok = 1'b1;
        endcase
    end

    // Slot 2 sees credit net of slot 1's allocation: a same-class pair needs
    // two free entries. Two MULs never pair because there is one MUL port.
    always_comb begin
        w_slot2_ok = 1'b1;
        case (w_class2)
            CLS_ALU: w_slot2_ok = (w_class1 == CLS_ALU) ? (r_free_alu > c_ALU_W'(1))
                                                        : (r_free_alu != '0);
            CLS_MUL: w_slot2_ok = (w_class1 != CLS_MUL) && (r_free_mul != '0);
            CLS_LD:  w_slot2_ok = (w_class1 == CLS_LD)  ? (r_free_ld > c_LD_W'(1))
                                                        : (r_free_ld != '0);
            default: w_slot2_ok = 1'b1;
        endcase
    end

    assign w_d1 = w_run && w_slot1_ok;
    assign w_d2 = w_d1 && w_slot2_ok;

    assign disp1_valid = w_d1;
    assign disp2_valid = w_d2;
    assign disp1_class = w_d1 ? w_class1 : CLS_NOP;
    assign disp2_class = w_d2 ? w_class2 : CLS_NOP;
    assign shift_count = {1'b0, w_d1} + {1'b0, w_d2};
    assign stall_count = r_stall;

    assign w_alloc_alu = 2'(w_d1 && (w_class1 == CLS_ALU)) + 2'(w_d2 && (w_class2 == CLS_ALU));
    assign w_alloc_mul = 2'(w_d1 && (w_class1 == CLS_MUL)) + 2'(w_d2 && (w_class2 == CLS_MUL));
    assign w_alloc_ld  = 2'(w_d1 && (w_class1 == CLS_LD))  + 2'(w_d2 && (w_class2 == CLS_LD));

    // Allocation never exceeds credit, so the sum cannot underflow. It only
    // exceeds the maximum for a release against a full, unallocated pool,
    // which is clamped away.
    assign w_alu_sum = {1'b0, r_free_alu} - (c_ALU_W+1)'(w_alloc_alu) + (c_ALU_W+1)'(rel_alu);
    assign w_mul_sum = {1'b0, r_free_mul} - (c_MUL_W+1)'(w_alloc_mul) + (c_MUL_W+1)'(rel_mul);
    assign w_ld_sum  = {1'b0, r_free_ld}  - (c_LD_W+1)'(w_alloc_ld)   + (c_LD_W+1)'(rel_ld);

    assign w_alu_nxt = (w_alu_sum > {1'b0, c_ALU_MAX}) ? c_ALU_MAX : w_alu_sum[c_ALU_W-1:0];
    assign w_mul_nxt = (w_mul_sum > {1'b0, c_MUL_MAX}) ? c_MUL_MAX : w_mul_sum[c_MUL_W-1:0];
    assign w_ld_nxt  = (w_ld_sum  > {1'b0, c_LD_MAX})  ? c_LD_MAX  : w_ld_sum[c_LD_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= '0;
            r_free_alu <= c_ALU_MAX;
            r_free_mul <= c_MUL_MAX;
            r_free_ld  <= c_LD_MAX;
            r_stall    <= '0;
        end else if (flush) begin
            // Squashed instructions never return credit, so the pools are
            // restored wholesale and this cycle's releases are dropped.
            r_state    <= ST_HOLD;
            r_hold_cnt <= c_HOLD_INIT;
            r_free_alu <= c_ALU_MAX;
            r_free_mul <= c_MUL_MAX;
            r_free_ld  <= c_LD_MAX;
        end else begin
            r_free_alu <= w_alu_nxt;
            r_free_mul <= w_mul_nxt;
            r_free_ld  <= w_ld_nxt;
            case (r_state)
                ST_RUN: begin
                    if ((shift_count == 2'd0) && (r_stall != 16'hFFFF)) begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule : dispatch_ctrl
`default_nettype wire
